// File: rtl/dtl_gm_slave_if.sv
// DTL command/write/read channel bundle between the core's DMEM master and dtl_gm_slave.
interface dtl_gm_slave_if #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5
);
    logic                               DTL_CommandValid;
    logic                               DTL_CommandAccept;
    logic                               DTL_CommandReadWrite;
    logic [INTERFACE_ADDR_WIDTH-1:0]    DTL_Address;
    logic [INTERFACE_BLOCK_WIDTH-1:0]   DTL_BlockSize;
    logic                               DTL_WriteValid;
    logic                               DTL_WriteAccept;
    logic [INTERFACE_WIDTH-1:0]         DTL_WriteData;
    logic [INTERFACE_WIDTH/8-1:0]       DTL_WriteEnable;
    logic                               DTL_WriteLast;
    logic                               DTL_ReadValid;
    logic                               DTL_ReadAccept;
    logic [INTERFACE_WIDTH-1:0]         DTL_ReadData;
    logic                               DTL_ReadLast;

    modport master (
        output DTL_CommandValid, DTL_CommandReadWrite, DTL_Address, DTL_BlockSize,
               DTL_WriteValid, DTL_WriteData, DTL_WriteEnable, DTL_WriteLast,
               DTL_ReadAccept,
        input  DTL_CommandAccept, DTL_WriteAccept, DTL_ReadValid, DTL_ReadData, DTL_ReadLast
    );

    modport slave (
        input  DTL_CommandValid, DTL_CommandReadWrite, DTL_Address, DTL_BlockSize,
               DTL_WriteValid, DTL_WriteData, DTL_WriteEnable, DTL_WriteLast,
               DTL_ReadAccept,
        output DTL_CommandAccept, DTL_WriteAccept, DTL_ReadValid, DTL_ReadData, DTL_ReadLast
    );
endinterface

// File: rtl/dtl_gm_slave.sv
// DTL slave terminating the core's global-memory port onto a single-port SRAM, one burst at a time.
// Optional `DTL_GM_LAST_CHECK_EN adds a sticky oError for WriteLast/BlockSize protocol violations.
module dtl_gm_slave #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int MEM_ADDR_WIDTH        = 10
) (
    input  logic                           iClk,
    input  logic                           iReset,
    dtl_gm_slave_if.slave                  dtl,
    output logic [MEM_ADDR_WIDTH-1:0]      oMem_Address,
    output logic [INTERFACE_WIDTH/8-1:0]   oMem_WriteEnable,
    output logic                           oMem_ReadEnable,
    output logic [INTERFACE_WIDTH-1:0]     oMem_WriteData,
    input  logic [INTERFACE_WIDTH-1:0]     iMem_ReadData
`ifdef DTL_GM_LAST_CHECK_EN
    ,
    output logic                           oError
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_RSP
    } state_t;

    state_t                             r_state;
    state_t                             w_next;
    logic [MEM_ADDR_WIDTH-1:0]          r_addr;
    logic [INTERFACE_BLOCK_WIDTH-1:0]   r_count;
    logic [INTERFACE_WIDTH-1:0]         r_rdata;

    logic                               w_last;
    logic                               w_cmd_fire;
    logic                               w_wr_fire;
    logic                               w_rd_fire;
    logic                               w_unused;

    assign w_last       = (r_count == '0);
    assign oMem_Address = r_addr;
    assign dtl.DTL_ReadData = r_rdata;

    // Handshake outputs are gated by iReset so nothing is accepted or strobed while reset is held.
    always_comb begin
        w_next                = r_state;
        w_cmd_fire            = 1'b0;
        w_wr_fire             = 1'b0;
        w_rd_fire             = 1'b0;
        dtl.DTL_CommandAccept = 1'b0;
        dtl.DTL_WriteAccept   = 1'b0;
        dtl.DTL_ReadValid     = 1'b0;
        dtl.DTL_ReadLast      = 1'b0;
        oMem_WriteEnable      = '0;
        oMem_WriteData        = '0;
        oMem_ReadEnable       = 1'b0;
        if (!iReset) begin
            case (r_state)
                ST_IDLE: begin
                    dtl.DTL_CommandAccept = 1'b1;
                    if (dtl.DTL_CommandValid) begin
                        w_cmd_fire = 1'b1;
                        w_next     = dtl.DTL_CommandReadWrite ? ST_WR : ST_RD_REQ;
                    end
                end
                ST_WR: begin
                    dtl.DTL_WriteAccept = 1'b1;
                    if (dtl.DTL_WriteValid) begin
                        w_wr_fire        = 1'b1;
                        oMem_WriteEnable = dtl.DTL_WriteEnable;
                        oMem_WriteData   = dtl.DTL_WriteData;
                        if (w_last) begin
                            w_next = ST_IDLE;
                        end
                    end
                end
                ST_RD_REQ: begin
                    oMem_ReadEnable = 1'b1;
                    w_next          = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    w_next = ST_RD_RSP;
                end
                ST_RD_RSP: begin
                    dtl.DTL_ReadValid = 1'b1;
                    dtl.DTL_ReadLast  = w_last;
                    if (dtl.DTL_ReadAccept) begin
                        w_rd_fire = 1'b1;
                        w_next    = w_last ? ST_IDLE : ST_RD_REQ;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_cmd_fire) begin
                r_addr  <= dtl.DTL_Address[MEM_ADDR_WIDTH+1:2];
                r_count <= dtl.DTL_BlockSize;
            end else if (w_wr_fire || (w_rd_fire && !w_last)) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= r_count - 1'b1;
            end
            if (r_state == ST_RD_WAIT) begin
                r_rdata <= iMem_ReadData;
            end
        end
    end

`ifdef DTL_GM_LAST_CHECK_EN
    localparam logic [63:0] MAX_BLK = (64'd1 << MEM_ADDR_WIDTH) - 64'd1;

    logic r_error;
    logic w_blk_too_big;

    assign w_blk_too_big = 64'(dtl.DTL_BlockSize) > MAX_BLK;
    assign oError        = r_error;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_error <= 1'b0;
        end else if ((w_cmd_fire && w_blk_too_big) ||
                     (w_wr_fire && (dtl.DTL_WriteLast != w_last))) begin
            r_error <= 1'b1;
        end
    end

    assign w_unused = ^dtl.DTL_Address;
`else
    assign w_unused = ^{dtl.DTL_Address, dtl.DTL_WriteLast};
`endif

endmodule
